// File: rtl/dp_test_sequencer.sv
// Double-pulse gate sequencer: qualifies the DC-link voltage against a window,
// latches driver faults and plays an arm/pulse/gap/pulse pattern on selected channels.
module dp_test_sequencer #(
  parameter int unsigned       N_CH      = 4,
  parameter int unsigned       VOLT_W    = 16,
  parameter logic [VOLT_W-1:0] V_LO      = VOLT_W'(16'h08B0),
  parameter logic [VOLT_W-1:0] V_HI      = VOLT_W'(16'h0C0C),
  parameter int unsigned       ARM_DELAY = 200_000_000,
  parameter int unsigned       T_ON1     = 2000,
  parameter int unsigned       T_OFF     = 500,
  parameter int unsigned       T_ON2     = 1000,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic [VOLT_W-1:0] volt,
  input  logic              volt_valid,
  input  logic              trig,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   fault_n,
  input  logic              fault_clr,
  output logic [N_CH-1:0]   k,
  output logic [N_CH-1:0]   fault_lat,
  output logic [1:0]        zone,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  typedef enum logic [1:0] {ZoneNone, ZoneUnder, ZoneOk, ZoneOver} zone_e;
  typedef enum logic [2:0] {StIdle, StArm, StPulse1, StGap, StPulse2, StDone} state_e;

  // Each phase ends on the edge where the counter holds its last in-phase value.
  localparam logic [CNT_W-1:0] ArmLast  = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] On1Last  = CNT_W'(T_ON1 - 1);
  localparam logic [CNT_W-1:0] OffLast  = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] On2Last  = CNT_W'(T_ON2 - 1);

  zone_e             zone_q, zone_d;
  logic [N_CH-1:0]   fault_lat_q, fault_lat_d;
  state_e            state_q, next_phase;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_CH-1:0]   ch_sel_q, k_q;
  logic              busy_q, done_q, abort_q;
  logic              fault_any, volt_ok, run_ok, arm_go, phase_last;

  always_comb begin
    zone_d = zone_q;
    if (volt_valid) begin
      if (volt == '0) begin
        zone_d = ZoneNone;
      end else if (volt <= V_LO) begin
        zone_d = ZoneUnder;
      end else if (volt <= V_HI) begin
        zone_d = ZoneOk;
      end else begin
        zone_d = ZoneOver;
      end
    end
  end

  // A fault arriving together with fault_clr must survive the clear.
  assign fault_lat_d = (fault_clr ? '0 : fault_lat_q) | ~fault_n;

  assign fault_any = (|fault_lat_q) || !(&fault_n);
  assign volt_ok   = (zone_q == ZoneOk);
  assign run_ok    = volt_ok && !fault_any;
  assign arm_go    = trig && run_ok && (|ch_en);

  always_comb begin
    phase_last = 1'b0;
    next_phase = StIdle;
    case (state_q)
      StArm:    begin phase_last = (cnt_q == ArmLast); next_phase = StPulse1; end
      StPulse1: begin phase_last = (cnt_q == On1Last); next_phase = StGap;    end
      StGap:    begin phase_last = (cnt_q == OffLast); next_phase = StPulse2; end
      StPulse2: begin phase_last = (cnt_q == On2Last); next_phase = StDone;   end
      default:  begin phase_last = 1'b0;               next_phase = StIdle;   end
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      zone_q      <= ZoneNone;
      fault_lat_q <= '0;
    end else begin
      zone_q      <= zone_d;
      fault_lat_q <= fault_lat_d;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ch_sel_q <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arm_go) begin
            state_q  <= StArm;
            cnt_q    <= '0;
            ch_sel_q <= ch_en;
            busy_q   <= 1'b1;
          end
        end
        StArm, StPulse1, StGap, StPulse2: begin
          if (!run_ok) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
          end else if (phase_last) begin
            state_q <= next_phase;
            cnt_q   <= '0;
            k_q     <= (next_phase == StPulse1 || next_phase == StPulse2) ? ch_sel_q : '0;
            done_q  <= (next_phase == StDone);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          k_q     <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign k         = k_q;
  assign fault_lat = fault_lat_q;
  assign zone      = zone_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_dp_test_sequencer.sv
// Bench for dp_test_sequencer: directed scenarios plus random stimulus, all checked
// against a time-since-trigger reference model.
module tb_dp_test_sequencer;

  localparam int unsigned AD    = 10;
  localparam int unsigned T1    = 5;
  localparam int unsigned TOFF  = 3;
  localparam int unsigned T2    = 2;
  localparam int unsigned TOTAL = AD + T1 + TOFF + T2;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] volt = '0;
  logic        volt_valid = 1'b0;
  logic        trig = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [3:0]  fault_n = 4'hF;
  logic        fault_clr = 1'b0;
  logic [3:0]  k, fault_lat;
  logic [1:0]  zone;
  logic        busy, done, abort;

  int checks = 0;
  int errors = 0;

  // Reference model: run flag plus cycles elapsed since the accepting edge.
  logic        m_active;
  int unsigned m_t;
  logic [3:0]  m_sel, m_lat;
  logic [1:0]  m_zone;
  logic        m_abort;

  dp_test_sequencer #(
    .N_CH(4), .VOLT_W(16), .V_LO(16'h08B0), .V_HI(16'h0C0C),
    .ARM_DELAY(AD), .T_ON1(T1), .T_OFF(TOFF), .T_ON2(T2), .CNT_W(32)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .volt(volt), .volt_valid(volt_valid),
    .trig(trig), .ch_en(ch_en), .fault_n(fault_n), .fault_clr(fault_clr),
    .k(k), .fault_lat(fault_lat), .zone(zone), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] zone_of(input logic [15:0] v);
    if (v == 16'h0000) return 2'd0;
    if (v <= 16'h08B0) return 2'd1;
    if (v <= 16'h0C0C) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [3:0] ek;
    ek = '0;
    if (m_active && ((m_t >= AD && m_t < AD + T1) || (m_t >= AD + T1 + TOFF && m_t < TOTAL)))
      ek = m_sel;
    return {ek, m_lat, m_zone, m_active, m_active && (m_t == TOTAL), m_abort};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {k, fault_lat, zone, busy, done, abort};
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_t = 0; m_sel = '0; m_lat = '0; m_zone = 2'd0; m_abort = 1'b0;
  endtask

  // Advance the model with the pre-edge inputs, then step the DUT one edge.
  task automatic tick();
    logic f_any, ok;
    f_any = (m_lat != 4'h0) || (fault_n != 4'hF);
    ok = (m_zone == 2'd2);
    m_abort = 1'b0;
    if (m_active) begin
      if (m_t < TOTAL && (f_any || !ok)) begin
        m_active = 1'b0;
        m_abort = 1'b1;
      end else if (m_t == TOTAL) begin
        m_active = 1'b0;
      end else begin
        m_t++;
      end
    end else if (trig && ok && !f_any && ch_en != 4'h0) begin
      m_active = 1'b1;
      m_t = 0;
      m_sel = ch_en;
    end
    if (volt_valid) m_zone = zone_of(volt);
    m_lat = (fault_clr ? 4'h0 : m_lat) | ~fault_n;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_volt(input logic [15:0] v);
    volt = v; volt_valid = 1'b1;
    tick();
    volt_valid = 1'b0;
  endtask

  task automatic pulse_trig(input logic [3:0] en);
    ch_en = en; trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #7;
    checks++;
    if (dut_vec() !== 13'h0) begin
      errors++; $display("FAIL reset_held: got %h expected %h", dut_vec(), 13'h0);
    end
    sys_rst_n = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_nominal();
    int rise_c, done_c, high_n;
    logic abort_seen;
    rise_c = -1; done_c = -1; high_n = 0; abort_seen = 1'b0;
    strobe_volt(16'h0A00);
    pulse_trig(4'b0101);
    checks++;
    if (busy !== 1'b1 || k !== 4'h0) begin
      errors++; $display("FAIL nominal_e0: got busy=%b k=%h expected busy=1 k=0", busy, k);
    end
    for (int c = 1; c <= TOTAL + 2; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL nominal c%0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
      if (k == 4'b0101 && rise_c < 0) rise_c = c;
      if (k == 4'b0101) high_n++;
      if (done === 1'b1) done_c = c;
      if (abort === 1'b1) abort_seen = 1'b1;
    end
    checks++;
    if (rise_c != int'(AD) || done_c != int'(TOTAL) || high_n != int'(T1 + T2) || abort_seen) begin
      errors++;
      $display("FAIL nominal_timing: got rise=%0d done=%0d high=%0d abort=%b expected 10 20 7 0",
               rise_c, done_c, high_n, abort_seen);
    end
  endtask

  task automatic test_voltage_gating();
    logic [15:0] vs [3];
    logic [1:0]  zs [3];
    vs = '{16'h0800, 16'h0C0D, 16'h0C0C};
    zs = '{2'd1, 2'd3, 2'd2};
    for (int i = 0; i < 3; i++) begin
      strobe_volt(vs[i]);
      checks++;
      if (zone !== zs[i]) begin
        errors++; $display("FAIL gating_zone%0d: got %0d expected %0d", i, zone, zs[i]);
      end
      if (i < 2) begin
        pulse_trig(4'b1111);
        tick();
        checks++;
        if (busy !== 1'b0 || k !== 4'h0 || dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL gating_trig%0d: got %h expected %h", i, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_fault_abort();
    pulse_trig(4'b1111);
    repeat (AD + 1) tick();
    fault_n = 4'b1011;
    tick();
    fault_n = 4'hF;
    checks++;
    if (k !== 4'h0 || abort !== 1'b1 || fault_lat !== 4'b0100) begin
      errors++;
      $display("FAIL fault_abort: got k=%h abort=%b lat=%h expected k=0 abort=1 lat=4",
               k, abort, fault_lat);
    end
    pulse_trig(4'b0011);
    tick();
    checks++;
    if (busy !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL fault_rearm_blocked: got %h expected %h", dut_vec(), exp_vec());
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    pulse_trig(4'b0011);
    checks++;
    if (busy !== 1'b1 || fault_lat !== 4'h0) begin
      errors++; $display("FAIL fault_rearm: got busy=%b lat=%h expected 1 0", busy, fault_lat);
    end
    for (int c = 1; c <= TOTAL + 1; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL fault_rerun c%0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_voltage_abort();
    logic k_seen;
    k_seen = 1'b0;
    pulse_trig(4'b1001);
    repeat (AD + T1) tick();
    strobe_volt(16'h0900);
    checks++;
    if (abort !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL vabort_still_ok: got abort=%b busy=%b expected 0 1", abort, busy);
    end
    strobe_volt(16'h0D00);
    checks++;
    if (abort !== 1'b0 || zone !== 2'd3) begin
      errors++; $display("FAIL vabort_latency: got abort=%b zone=%0d expected 0 3", abort, zone);
    end
    tick();
    checks++;
    if (abort !== 1'b1 || busy !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL vabort: got %h expected %h", dut_vec(), exp_vec());
    end
    repeat (6) begin
      tick();
      if (k != 4'h0) k_seen = 1'b1;
    end
    checks++;
    if (k_seen) begin
      errors++; $display("FAIL vabort_no_pulse2: got k active expected k=0");
    end
    strobe_volt(16'h0A00);
  endtask

  task automatic test_boundary_races();
    int rise_c;
    rise_c = -1;
    fault_n = 4'b1110;
    pulse_trig(4'b1111);
    fault_n = 4'hF;
    checks++;
    if (busy !== 1'b0 || abort !== 1'b0 || fault_lat !== 4'b0001) begin
      errors++; $display("FAIL race_trig_fault: got %h expected %h", dut_vec(), exp_vec());
    end
    fault_clr = 1'b1; fault_n = 4'b1110;
    tick();
    fault_clr = 1'b0; fault_n = 4'hF;
    checks++;
    if (fault_lat !== 4'b0001) begin
      errors++; $display("FAIL race_clr_fault: got lat=%h expected 1", fault_lat);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    pulse_trig(4'b0110);
    for (int c = 1; c <= TOTAL + 1; c++) begin
      if (c == 3) begin ch_en = 4'b1111; trig = 1'b1; end
      tick();
      trig = 1'b0;
      if (k != 4'h0 && rise_c < 0) rise_c = c;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL race_busy_trig c%0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (rise_c != int'(AD)) begin
      errors++; $display("FAIL race_busy_timing: got rise=%0d expected %0d", rise_c, AD);
    end
    pulse_trig(4'b0000);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL race_ch_en_zero: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      trig = ($urandom_range(0, 9) == 0);
      ch_en = 4'($urandom_range(0, 15));
      fault_clr = ($urandom_range(0, 19) == 0);
      fault_n = ($urandom_range(0, 99) == 0) ? (4'hF ^ (4'b0001 << 2'($urandom_range(0, 3))))
                                              : 4'hF;
      volt_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0: volt = 16'h0000;
        1: volt = 16'h08B0;
        2: volt = 16'h0C0D;
        3: volt = 16'($urandom_range(0, 65535));
        default: volt = 16'($urandom_range(16'h08B1, 16'h0C0C));
      endcase
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random c%0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
    end
    trig = 1'b0; volt_valid = 1'b0; fault_n = 4'hF;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    strobe_volt(16'h0A00);
    repeat (TOTAL + 2) tick();
  endtask

  task automatic test_reset_mid_pulse2();
    pulse_trig(4'b1100);
    repeat (AD + T1 + TOFF) tick();
    checks++;
    if (k !== 4'b1100) begin
      errors++; $display("FAIL rst_pre_pulse2: got k=%h expected c", k);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (k !== 4'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async_k: got k=%h busy=%b expected 0 0", k, busy);
    end
    #1 sys_rst_n = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec() || zone !== 2'd0) begin
      errors++; $display("FAIL rst_after: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_voltage_gating();
    test_fault_abort();
    test_voltage_abort();
    test_boundary_races();
    test_random();
    test_reset_mid_pulse2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
